fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_skid_buffer.sv | 97 +++++++++
 rtl/fifo_stream_reader.sv | 98 +++++++++
 tb/tb_fifo_stream_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO stream reader: state encoding, default
// geometry and the counter-width helper.
package fifo_pkg;

    localparam int unsigned DEF_BITS  = 8;
    localparam int unsigned DEF_BURST = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Two-entry registered output buffer. The head entry drives the stream
// outputs directly, so data, last and valid all come straight from flops.
module fifo_skid_buffer
    import fifo_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [BITS-1:0] push_data_i,
    input  logic            push_last_i,
    input  logic            ready_i,
    output logic [BITS-1:0] data_o,
    output logic            last_o,
    output logic            valid_o,
    output logic [1:0]      occ_o
);

    logic [BITS-1:0] head_data_q, head_data_d;
    logic [BITS-1:0] tail_data_q, tail_data_d;
    logic            head_last_q, head_last_d;
    logic            tail_last_q, tail_last_d;
    logic [1:0]      occ_q, occ_d;
    logic            valid_q, valid_d;
    logic            xfer;

    assign xfer = valid_q & ready_i;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        occ_d       = occ_q;

        unique case (occ_q)
            2'd0: begin
                if (push_i) begin
                    head_data_d = push_data_i;
                    head_last_d = push_last_i;
                    occ_d       = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && xfer) begin
                    // Head leaves as the new word arrives: it becomes the head.
                    head_data_d = push_data_i;
                    head_last_d = push_last_i;
                end else if (push_i) begin
                    tail_data_d = push_data_i;
                    tail_last_d = push_last_i;
                    occ_d       = 2'd2;
                end else if (xfer) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                // Full: a push is never accepted here, so the tail is never overwritten.
                if (xfer) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    occ_d       = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase

        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, because M_DATA must read 0 out of reset.
        if (rst) begin
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
            occ_q       <= 2'd0;
            valid_q     <= 1'b0;
        end else begin
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            occ_q       <= occ_d;
            valid_q     <= valid_d;
        end
    end

    assign data_o  = head_data_q;
    assign last_o  = head_last_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a FIFO in fixed-size bursts and streams the words out with a last
// marker; a burst once started is always completed before going idle.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned BITS  = DEF_BITS,
    parameter int unsigned BURST = DEF_BURST
) (
    input  logic            RCLK,
    input  logic            RESET,
    input  logic            ENABLE,
    input  logic            EMPTY,
    input  logic [BITS-1:0] Q,
    output logic            RE,
    output logic [BITS-1:0] M_DATA,
    output logic            M_VALID,
    input  logic            M_READY,
    output logic            M_LAST,
    output logic            BUSY
);

    localparam int unsigned PW = cnt_width(BURST);

    state_e          state_q, state_d;
    logic [PW-1:0]   popcnt_q, popcnt_d;
    logic [1:0]      occ;
    logic            pop_ok;
    logic            last_bit;

    assign last_bit = (popcnt_q == PW'(BURST - 1));

    always_comb begin
        pop_ok = 1'b0;
        unique case (state_q)
            RUN:     pop_ok = 1'b1;
            DRAIN:   pop_ok = (popcnt_q != '0);
            default: pop_ok = 1'b0;
        endcase
    end

    // Combinational pop strobe; reset gating keeps the FIFO untouched while RESET is high.
    assign RE = pop_ok & ~EMPTY & (occ < 2'd2) & ~RESET;

    always_comb begin
        popcnt_d = popcnt_q;
        if (RE) begin
            popcnt_d = last_bit ? '0 : popcnt_q + PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ENABLE) state_d = RUN;
            end
            RUN: begin
                if (!ENABLE) state_d = DRAIN;
            end
            DRAIN: begin
                if (ENABLE) begin
                    state_d = RUN;
                end else if (popcnt_q == '0 && occ == 2'd0 && !RE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge RCLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            popcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            popcnt_q <= popcnt_d;
        end
    end

    fifo_skid_buffer #(
        .BITS(BITS)
    ) u_buf (
        .clk         (RCLK),
        .rst         (RESET),
        .push_i      (RE),
        .push_data_i (Q),
        .push_last_i (last_bit),
        .ready_i     (M_READY),
        .data_o      (M_DATA),
        .last_o      (M_LAST),
        .valid_o     (M_VALID),
        .occ_o       (occ)
    );

    assign BUSY = (state_q != IDLE) | (occ != 2'd0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, the
// stimulus pushes expected words, and a monitor checks every transfer.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int BITS  = 8;
    localparam int BURST = 4;
    localparam int DEPTH = 16384;

    logic            RCLK = 1'b0;
    logic            RESET, ENABLE, EMPTY, RE, M_VALID, M_READY, M_LAST, BUSY;
    logic [BITS-1:0] Q, M_DATA;

    always #5 RCLK = ~RCLK;

    fifo_stream_reader #(.BITS(BITS), .BURST(BURST)) dut (
        .RCLK    (RCLK),
        .RESET   (RESET),
        .ENABLE  (ENABLE),
        .EMPTY   (EMPTY),
        .Q       (Q),
        .RE      (RE),
        .M_DATA  (M_DATA),
        .M_VALID (M_VALID),
        .M_READY (M_READY),
        .M_LAST  (M_LAST),
        .BUSY    (BUSY)
    );

    // FIFO model: stimulus writes mem/wr_ptr, the pop side advances on RE.
    logic [BITS-1:0] mem [0:DEPTH-1];
    int   rd_ptr = 0;
    int   wr_ptr = 0;
    int   cyc    = 0;
    logic stall  = 1'b0;
    logic flush  = 1'b0;

    assign EMPTY = (rd_ptr == wr_ptr) | stall;
    assign Q     = mem[rd_ptr % DEPTH];

    always @(posedge RCLK) begin
        cyc <= cyc + 1;
        if (flush)   rd_ptr <= wr_ptr;
        else if (RE) rd_ptr <= rd_ptr + 1;
    end

    typedef struct packed {
        logic [BITS-1:0] data;
        logic            last;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int re_count, xfer_count, first_re_cyc, first_xfer_cyc, last_xfer_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic            hold_q = 1'b0;
    logic [BITS-1:0] hold_data;
    logic            hold_last;

    always @(negedge RCLK) begin
        exp_t e;
        if (RESET) check("re_low_in_reset", RE, 0);
        if (RE) begin
            check("no_pop_when_empty", EMPTY, 0);
            re_count++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
        end
        if (hold_q && !RESET) begin
            check("hold_valid", M_VALID, 1);
            check("hold_data", M_DATA, hold_data);
            check("hold_last", M_LAST, hold_last);
        end
        hold_q    = M_VALID & ~M_READY & ~RESET;
        hold_data = M_DATA;
        hold_last = M_LAST;
        if (M_VALID && M_READY && !RESET) begin
            xfer_count++;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer: got data %0h, no word expected (cycle %0d)", M_DATA, cyc);
            end else begin
                e = exp_q.pop_front();
                check("xfer_data", M_DATA, e.data);
                check("xfer_last", M_LAST, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge RCLK);
        #1;
    endtask

    task automatic reset_stats();
        re_count       = 0;
        xfer_count     = 0;
        first_re_cyc   = -1;
        first_xfer_cyc = -1;
        last_xfer_cyc  = -1;
    endtask

    task automatic load(input logic [BITS-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % DEPTH] = base + BITS'(i);
            wr_ptr++;
        end
    endtask

    task automatic push_exp(input logic [BITS-1:0] d, input logic l);
        exp_q.push_back('{data: d, last: l});
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        RESET  = 1'b1;
        ENABLE = 1'b0;
        tick();
        RESET  = 1'b0;
        check("rst_valid", M_VALID, 0);
        check("rst_last", M_LAST, 0);
        check("rst_data", M_DATA, 0);
        check("rst_busy", BUSY, 0);
        check("rst_re", RE, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        RESET   = 1'b1;
        ENABLE  = 1'b0;
        M_READY = 1'b0;
        reset_stats();
        repeat (2) tick();
        do_reset();

        // Eight words, continuous flow.
        do_flush();
        do_reset();
        reset_stats();
        load(8'h11, 8);
        for (int i = 0; i < 8; i++) push_exp(8'h11 + 8'(i), (i == 3) || (i == 7));
        M_READY = 1'b1;
        ENABLE  = 1'b1;
        repeat (14) tick();
        check("s1_xfers", xfer_count, 8);
        check("s1_pops", re_count, 8);
        check("s1_latency", first_xfer_cyc - first_re_cyc, 1);
        check("s1_back_to_back", last_xfer_cyc - first_xfer_cyc, 7);
        check("s1_exp_left", exp_q.size(), 0);
        ENABLE = 1'b0;
        repeat (3) tick();
        check("s1_idle_busy", BUSY, 0);

        // ENABLE drops mid-burst: the burst still completes.
        do_reset();
        reset_stats();
        load(8'hA0, 6);
        push_exp(8'hA0, 0);
        push_exp(8'hA1, 0);
        push_exp(8'hA2, 0);
        push_exp(8'hA3, 1);
        M_READY = 1'b1;
        ENABLE  = 1'b1;
        repeat (3) tick();
        ENABLE = 1'b0;
        repeat (8) tick();
        check("s2_pops", re_count, 4);
        check("s2_exp_left", exp_q.size(), 0);
        check("s2_busy", BUSY, 0);
        check("s2_fifo_left", wr_ptr - rd_ptr, 2);
        check("s2_fifo_head", Q, 8'hA4);
        check("s2_re", RE, 0);

        // Backpressure: buffer fills to two, then popping stops.
        do_flush();
        do_reset();
        reset_stats();
        load(8'h31, 4);
        for (int i = 0; i < 4; i++) push_exp(8'h31 + 8'(i), i == 3);
        M_READY = 1'b0;
        ENABLE  = 1'b1;
        repeat (7) tick();
        check("s3_pops_stalled", re_count, 2);
        check("s3_valid", M_VALID, 1);
        check("s3_data", M_DATA, 8'h31);
        check("s3_re", RE, 0);
        M_READY = 1'b1;
        repeat (6) tick();
        check("s3_pops", re_count, 4);
        check("s3_exp_left", exp_q.size(), 0);
        ENABLE = 1'b0;
        repeat (3) tick();
        check("s3_busy", BUSY, 0);

        // FIFO runs dry after two words of a burst.
        do_reset();
        reset_stats();
        load(8'h41, 4);
        for (int i = 0; i < 4; i++) push_exp(8'h41 + 8'(i), i == 3);
        M_READY = 1'b1;
        ENABLE  = 1'b1;
        repeat (3) tick();
        stall = 1'b1;
        repeat (6) tick();
        check("s4_pops_stalled", re_count, 2);
        check("s4_exp_mid", exp_q.size(), 2);
        check("s4_valid_gap", M_VALID, 0);
        stall = 1'b0;
        repeat (5) tick();
        check("s4_pops", re_count, 4);
        check("s4_exp_left", exp_q.size(), 0);
        ENABLE = 1'b0;
        repeat (3) tick();
        check("s4_busy", BUSY, 0);

        // Reset with a full buffer and a half-done burst.
        do_reset();
        reset_stats();
        load(8'h51, 6);
        M_READY = 1'b0;
        ENABLE  = 1'b1;
        repeat (3) tick();
        check("s5_pre_pops", re_count, 2);
        check("s5_pre_valid", M_VALID, 1);
        RESET  = 1'b1;
        ENABLE = 1'b0;
        check("s5_re_in_reset", RE, 0);
        tick();
        RESET = 1'b0;
        check("s5_valid", M_VALID, 0);
        check("s5_busy", BUSY, 0);
        check("s5_re", RE, 0);
        exp_q.delete();
        push_exp(8'h53, 0);
        push_exp(8'h54, 0);
        push_exp(8'h55, 0);
        push_exp(8'h56, 1);
        reset_stats();
        M_READY = 1'b1;
        ENABLE  = 1'b1;
        repeat (8) tick();
        check("s5_pops", re_count, 4);
        check("s5_exp_left", exp_q.size(), 0);
        ENABLE = 1'b0;
        repeat (3) tick();
        check("s5_busy", BUSY, 0);
        check("s5_fifo_empty", wr_ptr - rd_ptr, 0);

        // Random traffic against the scoreboard.
        do_flush();
        do_reset();
        reset_stats();
        k = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 99) < 55) begin
                mem[wr_ptr % DEPTH] = 8'(k * 7 + 3);
                wr_ptr++;
                push_exp(8'(k * 7 + 3), (k % 4) == 3);
                k++;
            end
            stall   = ($urandom_range(0, 99) < 25);
            M_READY = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3) ENABLE = ~ENABLE;
            tick();
        end
        stall   = 1'b0;
        M_READY = 1'b1;
        ENABLE  = 1'b0;
        for (int c = 0; c < 300 && BUSY; c++) begin
            if (EMPTY) begin
                mem[wr_ptr % DEPTH] = 8'(k * 7 + 3);
                wr_ptr++;
                push_exp(8'(k * 7 + 3), (k % 4) == 3);
                k++;
            end
            tick();
        end
        check("rand_drained", BUSY, 0);
        check("rand_leftover", exp_q.size(), wr_ptr - rd_ptr);
        check("rand_whole_bursts", xfer_count % 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
